// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns a resolved EX branch/jump into a fetch redirect, flushes and drains refill bubbles.
// Optional counters are built when BRANCH_STATS_EN is defined; otherwise stat_* are tied to zero.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] ex_target,
  input  logic            pipe_stall,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misalign_exc,
  output logic            busy,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_bubbles
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  localparam int CW = DRAIN_CYCLES > 2 ? $clog2(DRAIN_CYCLES) : 1;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mis_q, mis_d;
  logic accept, taken, aligned;
  // The handshake cycle is the first of the DRAIN_CYCLES flushed cycles; cnt holds the ones left after it.
  always_comb begin
    accept  = state_q == IDLE && ex_valid && (ex_branch || ex_jump) && !pipe_stall;
    taken   = accept && branch_flag;
    aligned = ex_target[1:0] == 2'b00;
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = taken && !aligned;
    case (state_q)
      IDLE: if (taken && aligned) begin
        state_d = REDIRECT;
        pc_d    = ex_target;
      end
      REDIRECT: if (redir_ready) begin
        state_d = DRAIN_CYCLES == 1 ? IDLE : DRAIN;
        cnt_d   = CW'(DRAIN_CYCLES - 1);
      end
      DRAIN: if (!pipe_stall) begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q <= CW'(1) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end
  assign redir_valid  = state_q == REDIRECT;
  assign redir_pc     = pc_q;
  assign misalign_exc = mis_q;
  assign busy         = state_q != IDLE;
  assign flush_id_ex  = taken && aligned;
  assign flush_if_id  = flush_id_ex || busy;
`ifdef BRANCH_STATS_EN
  logic [31:0] branches_q, branches_d, taken_q, taken_d, bubbles_q, bubbles_d;
  always_comb begin
    branches_d = accept && ~&branches_q ? branches_q + 32'd1 : branches_q;
    taken_d    = taken && ~&taken_q ? taken_q + 32'd1 : taken_q;
    bubbles_d  = flush_if_id && ~&bubbles_q ? bubbles_q + 32'd1 : bubbles_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      taken_q    <= '0;
      bubbles_q  <= '0;
    end else begin
      branches_q <= branches_d;
      taken_q    <= taken_d;
      bubbles_q  <= bubbles_d;
    end
  end
  assign stat_branches = branches_q;
  assign stat_taken    = taken_q;
  assign stat_bubbles  = bubbles_q;
`else
  assign stat_branches = 32'h0;
  assign stat_taken    = 32'h0;
  assign stat_bubbles  = 32'h0;
`endif
endmodule
